window_update_ctl: RTL and testbench



---
 rtl/window_pkg.sv | 30 +++
 rtl/window_update_ctl_if.sv | 30 +++
 rtl/window_clamp.sv | 60 ++++++
 rtl/window_update_ctl.sv | 113 +++++++++++
 tb/tb_window_update_ctl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/window_pkg.sv
// Shared types for the run-time window controller: window record, flat-bus
// pack/unpack helpers and the commit FSM state encoding.
package window_pkg;

  localparam int WIN_WBITS    = 12;
  localparam int WIN_HBITS    = 12;
  localparam int WIN_BUS_BITS = 2 * (WIN_WBITS + WIN_HBITS);

  // Field order matches the requester bus: {left, width, top, height}
  typedef struct packed {
    logic [WIN_WBITS-1:0] left;
    logic [WIN_WBITS-1:0] width;
    logic [WIN_HBITS-1:0] top;
    logic [WIN_HBITS-1:0] height;
  } win_t;

  typedef enum logic {
    IDLE,
    PENDING
  } win_state_e;

  function automatic logic [WIN_BUS_BITS-1:0] win_pack(input win_t w);
    return w;
  endfunction

  function automatic win_t win_unpack(input logic [WIN_BUS_BITS-1:0] b);
    return win_t'(b);
  endfunction

endpackage

// File: rtl/window_update_ctl_if.sv
// Requester handshakes, start-of-frame and active-window outputs of the
// window controller; master = requesters/consumers, slave = controller.
interface window_update_ctl_if;
  import window_pkg::*;

  logic                    sof;
  logic                    s0_valid;
  logic                    s0_ready;
  logic [WIN_BUS_BITS-1:0] s0_win;
  logic                    s1_valid;
  logic                    s1_ready;
  logic [WIN_BUS_BITS-1:0] s1_win;
  logic [WIN_WBITS-1:0]    left;
  logic [WIN_WBITS-1:0]    width;
  logic [WIN_HBITS-1:0]    top;
  logic [WIN_HBITS-1:0]    height;
  logic                    pending;
  logic                    win_updated;

  modport master (
    output sof, s0_valid, s0_win, s1_valid, s1_win,
    input  s0_ready, s1_ready, left, width, top, height, pending, win_updated
  );

  modport slave (
    input  sof, s0_valid, s0_win, s1_valid, s1_win,
    output s0_ready, s1_ready, left, width, top, height, pending, win_updated
  );

endinterface

// File: rtl/window_clamp.sv
// Combinational clamp of a requested window to the image bounds.
// Clamping is compiled in with WINDOW_CLAMP_EN; otherwise the window passes through.
module window_clamp
  import window_pkg::*;
#(
  parameter int C_IMG_WIDTH  = 640,
  parameter int C_IMG_HEIGHT = 480
) (
  input  win_t i_win,
  output win_t o_win
);

  if (C_IMG_WIDTH < 1 || C_IMG_WIDTH > (1 << WIN_WBITS) ||
      C_IMG_HEIGHT < 1 || C_IMG_HEIGHT > (1 << WIN_HBITS)) begin : g_bad_bounds
    $error("window_clamp: image bounds do not fit the window field widths");
  end

`ifdef WINDOW_CLAMP_EN
  localparam logic [WIN_WBITS:0]   LP_IMG_W  = (WIN_WBITS+1)'(C_IMG_WIDTH);
  localparam logic [WIN_HBITS:0]   LP_IMG_H  = (WIN_HBITS+1)'(C_IMG_HEIGHT);
  localparam logic [WIN_WBITS-1:0] LP_W_LAST = WIN_WBITS'(C_IMG_WIDTH - 1);
  localparam logic [WIN_HBITS-1:0] LP_H_LAST = WIN_HBITS'(C_IMG_HEIGHT - 1);

  // One extra bit so left+width cannot wrap before the bound compare
  logic [WIN_WBITS:0] w_left;
  logic [WIN_WBITS:0] w_wid;
  logic [WIN_HBITS:0] w_top;
  logic [WIN_HBITS:0] w_hgt;

  assign w_left = {1'b0, i_win.left};
  assign w_wid  = {1'b0, i_win.width};
  assign w_top  = {1'b0, i_win.top};
  assign w_hgt  = {1'b0, i_win.height};

  always_comb begin
    o_win = i_win;

    if (w_left >= LP_IMG_W) begin
      o_win.left  = LP_W_LAST;
      o_win.width = WIN_WBITS'(1);
    end else if (w_wid == '0) begin
      o_win.width = WIN_WBITS'(1);
    end else if (w_left + w_wid > LP_IMG_W) begin
      o_win.width = WIN_WBITS'(LP_IMG_W - w_left);
    end

    if (w_top >= LP_IMG_H) begin
      o_win.top    = LP_H_LAST;
      o_win.height = WIN_HBITS'(1);
    end else if (w_hgt == '0) begin
      o_win.height = WIN_HBITS'(1);
    end else if (w_top + w_hgt > LP_IMG_H) begin
      o_win.height = WIN_HBITS'(LP_IMG_H - w_top);
    end
  end
`else
  assign o_win = i_win;
`endif

endmodule

// File: rtl/window_update_ctl.sv
// Arbitrates two window requesters, clamps into a shadow and commits the shadow
// atomically on start-of-frame. Clamping is enabled by WINDOW_CLAMP_EN.
module window_update_ctl
  import window_pkg::*;
#(
  parameter int C_HBITS      = WIN_HBITS,
  parameter int C_WBITS      = WIN_WBITS,
  parameter int C_IMG_WIDTH  = 640,
  parameter int C_IMG_HEIGHT = 480,
  parameter int C_LEFT       = 0,
  parameter int C_TOP        = 0,
  parameter int C_WIDTH      = 320,
  parameter int C_HEIGHT     = 240
) (
  input  logic                clk,
  input  logic                reset,
  window_update_ctl_if.slave  bus
);

  // win_t is sized by the package, so the field widths are fixed there
  if (C_WBITS != WIN_WBITS || C_HBITS != WIN_HBITS) begin : g_bad_width
    $error("window_update_ctl: C_WBITS/C_HBITS must match window_pkg widths");
  end

  localparam win_t LP_RST_WIN = '{
    left:   WIN_WBITS'(C_LEFT),
    width:  WIN_WBITS'(C_WIDTH),
    top:    WIN_HBITS'(C_TOP),
    height: WIN_HBITS'(C_HEIGHT)
  };

  win_state_e r_state;
  win_t       r_shadow;
  win_t       r_active;
  logic       r_pending;
  logic       r_win_upd;
  logic       r_rdy_en;

  win_t w_s0_win;
  win_t w_s1_win;
  win_t w_sel_win;
  win_t w_clamped;
  logic w_s0_xfer;
  logic w_s1_xfer;
  logic w_accept;

  assign w_s0_win  = win_unpack(bus.s0_win);
  assign w_s1_win  = win_unpack(bus.s1_win);

  // s0 has fixed priority; s1 is only ready while s0 is idle
  assign w_s0_xfer = r_rdy_en & bus.s0_valid;
  assign w_s1_xfer = r_rdy_en & ~bus.s0_valid & bus.s1_valid;
  assign w_accept  = w_s0_xfer | w_s1_xfer;
  assign w_sel_win = w_s0_xfer ? w_s0_win : w_s1_win;

  window_clamp #(
    .C_IMG_WIDTH  (C_IMG_WIDTH),
    .C_IMG_HEIGHT (C_IMG_HEIGHT)
  ) u_clamp (
    .i_win (w_sel_win),
    .o_win (w_clamped)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shadow  <= '0;
      r_active  <= LP_RST_WIN;
      r_pending <= 1'b0;
      r_win_upd <= 1'b0;
      r_rdy_en  <= 1'b0;
    end else begin
      r_rdy_en  <= 1'b1;
      r_win_upd <= 1'b0;
      if (w_accept) begin
        r_shadow <= w_clamped;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= PENDING;
            r_pending <= 1'b1;
          end
        end
        PENDING: begin
          // A request landing with sof refills the shadow after this commit
          if (bus.sof) begin
            r_active  <= r_shadow;
            r_win_upd <= 1'b1;
            if (!w_accept) begin
              r_state   <= IDLE;
              r_pending <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s0_ready    = r_rdy_en;
  assign bus.s1_ready    = r_rdy_en & ~bus.s0_valid;
  assign bus.left        = r_active.left;
  assign bus.width       = r_active.width;
  assign bus.top         = r_active.top;
  assign bus.height      = r_active.height;
  assign bus.pending     = r_pending;
  assign bus.win_updated = r_win_upd;

endmodule

// File: tb/tb_window_update_ctl.sv
// Scoreboard bench for window_update_ctl: stimulus queues expected commits,
// a negedge monitor checks each win_updated pulse against the queue.
module tb_window_update_ctl;
  import window_pkg::*;

`ifdef WINDOW_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  window_update_ctl_if bus ();

  window_update_ctl #(
    .C_HBITS(12), .C_WBITS(12), .C_IMG_WIDTH(640), .C_IMG_HEIGHT(480),
    .C_LEFT(0), .C_TOP(0), .C_WIDTH(320), .C_HEIGHT(240)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  win_t exp_q[$];

  win_t v_req [6];
  win_t v_clp [6];
  int   v_src [6];

  function automatic win_t mk(input int l, input int w, input int t, input int h);
    win_t r;
    r.left = 12'(l); r.width = 12'(w); r.top = 12'(t); r.height = 12'(h);
    return r;
  endfunction

  function automatic logic [47:0] pk(input win_t w);
    return {w.left, w.width, w.top, w.height};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_win(input string name, input win_t e);
    chk({name, ".left"},   32'(bus.left),   32'(e.left));
    chk({name, ".width"},  32'(bus.width),  32'(e.width));
    chk({name, ".top"},    32'(bus.top),    32'(e.top));
    chk({name, ".height"}, 32'(bus.height), 32'(e.height));
  endtask

  // Monitor: every commit pulse must match the oldest queued expectation
  always @(negedge clk) begin
    win_t e;
    if (reset === 1'b0 && bus.win_updated === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL commit: unexpected win_updated, window %0d/%0d/%0d/%0d",
                 bus.left, bus.width, bus.top, bus.height);
      end else begin
        e = exp_q.pop_front();
        if ({bus.left, bus.width, bus.top, bus.height} !== pk(e)) begin
          n_err++;
          $display("FAIL commit: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                   bus.left, bus.width, bus.top, bus.height,
                   e.left, e.width, e.top, e.height);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    win_t dflt;
    dflt = mk(0, 320, 0, 240);

    v_src[0] = 1; v_req[0] = mk(600, 100, 470, 0);   v_clp[0] = mk(600, 40, 470, 1);
    v_src[1] = 0; v_req[1] = mk(700, 5, 10, 10);     v_clp[1] = mk(639, 1, 10, 10);
    v_src[2] = 0; v_req[2] = mk(0, 640, 0, 480);     v_clp[2] = mk(0, 640, 0, 480);
    v_src[3] = 1; v_req[3] = mk(100, 100, 400, 200); v_clp[3] = mk(100, 100, 400, 80);
    v_src[4] = 0; v_req[4] = mk(0, 10, 500, 7);      v_clp[4] = mk(0, 10, 479, 1);
    v_src[5] = 1; v_req[5] = mk(639, 1, 479, 1);     v_clp[5] = mk(639, 1, 479, 1);

    reset        = 1'b1;
    bus.sof      = 1'b0;
    bus.s0_valid = 1'b0;
    bus.s0_win   = '0;
    bus.s1_valid = 1'b0;
    bus.s1_win   = '0;
    repeat (3) @(posedge clk);
    #1;

    chk_win("reset", dflt);
    chk("reset.pending", 32'(bus.pending), 0);
    chk("reset.win_updated", 32'(bus.win_updated), 0);
    chk("reset.s0_ready", 32'(bus.s0_ready), 0);
    chk("reset.s1_ready", 32'(bus.s1_ready), 0);

    reset = 1'b0;
    tick();
    chk("run.s0_ready", 32'(bus.s0_ready), 1);
    chk("run.s1_ready", 32'(bus.s1_ready), 1);

    bus.sof = 1'b1;
    tick();
    bus.sof = 1'b0;
    chk("idle_sof.win_updated", 32'(bus.win_updated), 0);
    chk("idle_sof.width", 32'(bus.width), 320);

    // Basic commit, sof three cycles after acceptance
    exp_q.push_back(mk(10, 100, 20, 50));
    bus.s0_valid = 1'b1;
    bus.s0_win   = pk(mk(10, 100, 20, 50));
    tick();
    bus.s0_valid = 1'b0;
    chk("basic.pending_n1", 32'(bus.pending), 1);
    tick();
    chk("basic.hold_n2", 32'(bus.width), 320);
    tick();
    bus.sof = 1'b1;
    tick();
    bus.sof = 1'b0;
    chk("basic.win_updated", 32'(bus.win_updated), 1);
    chk("basic.pending_clr", 32'(bus.pending), 0);
    chk_win("basic", mk(10, 100, 20, 50));
    tick();
    chk("basic.pulse_end", 32'(bus.win_updated), 0);
    chk("basic.hold_left", 32'(bus.left), 10);

    // Both requesters valid: s0 wins, s1 transfers in the following sof cycle
    bus.s0_valid = 1'b1;
    bus.s0_win   = pk(mk(5, 50, 6, 60));
    bus.s1_valid = 1'b1;
    bus.s1_win   = pk(mk(30, 40, 50, 60));
    #1;
    chk("arb.s1_ready_blocked", 32'(bus.s1_ready), 0);
    chk("arb.s0_ready", 32'(bus.s0_ready), 1);
    exp_q.push_back(mk(5, 50, 6, 60));
    tick();
    bus.s0_valid = 1'b0;
    #1;
    chk("arb.s1_ready_free", 32'(bus.s1_ready), 1);
    exp_q.push_back(mk(30, 40, 50, 60));
    bus.sof = 1'b1;
    tick();
    bus.sof      = 1'b0;
    bus.s1_valid = 1'b0;
    chk("arb.s0_commit_left", 32'(bus.left), 5);
    chk("arb.pending_kept", 32'(bus.pending), 1);
    tick();
    bus.sof = 1'b1;
    tick();
    bus.sof = 1'b0;
    chk_win("arb.s1_commit", mk(30, 40, 50, 60));
    chk("arb.pending_clr", 32'(bus.pending), 0);

    // Clamp boundary vectors
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(CLAMP_ON ? v_clp[i] : v_req[i]);
      if (v_src[i] == 0) begin
        bus.s0_valid = 1'b1;
        bus.s0_win   = pk(v_req[i]);
      end else begin
        bus.s1_valid = 1'b1;
        bus.s1_win   = pk(v_req[i]);
      end
      tick();
      bus.s0_valid = 1'b0;
      bus.s1_valid = 1'b0;
      chk("clamp.pending", 32'(bus.pending), 1);
      bus.sof = 1'b1;
      tick();
      bus.sof = 1'b0;
      chk("clamp.win_updated", 32'(bus.win_updated), 1);
      chk("clamp.width", 32'(bus.width), CLAMP_ON ? 32'(v_clp[i].width) : 32'(v_req[i].width));
    end

    // Request accepted in the sof cycle: old shadow commits, new one waits
    exp_q.push_back(mk(1, 2, 3, 4));
    bus.s0_valid = 1'b1;
    bus.s0_win   = pk(mk(1, 2, 3, 4));
    tick();
    bus.s0_valid = 1'b0;
    tick();
    exp_q.push_back(mk(7, 8, 9, 10));
    bus.s0_valid = 1'b1;
    bus.s0_win   = pk(mk(7, 8, 9, 10));
    bus.sof      = 1'b1;
    tick();
    bus.s0_valid = 1'b0;
    bus.sof      = 1'b0;
    chk("sofreq.old_left", 32'(bus.left), 1);
    chk("sofreq.pending", 32'(bus.pending), 1);
    tick();
    bus.sof = 1'b1;
    tick();
    bus.sof = 1'b0;
    chk("sofreq.new_left", 32'(bus.left), 7);
    chk("sofreq.pending_clr", 32'(bus.pending), 0);

    // Reset while a window is pending: shadow is discarded
    bus.s0_valid = 1'b1;
    bus.s0_win   = pk(mk(50, 60, 70, 80));
    tick();
    bus.s0_valid = 1'b0;
    chk("rst.pending_before", 32'(bus.pending), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_win("rst.async", dflt);
    chk("rst.pending", 32'(bus.pending), 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    bus.sof = 1'b1;
    tick();
    bus.sof = 1'b0;
    chk("rst.sof_no_update", 32'(bus.win_updated), 0);
    chk("rst.width_default", 32'(bus.width), 320);
    tick();
    chk("scoreboard.drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
